// File: rtl/io_cko_mode_ccff_loader_pkg.sv
// Shared types and sizing helpers for the cko pad-tile CCFF configuration loader.
package io_cko_ccff_pkg;

  localparam int unsigned MODE_W_DEFAULT = 7;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StApply,
    StHold,
    StRel
  } ccff_state_e;

  // The bit counter must reach MODE_W+2, the overshift marker.
  function automatic int unsigned cnt_w(input int unsigned mode_w);
    return $clog2(mode_w + 3);
  endfunction

endpackage

// File: rtl/io_cko_mode_ccff_loader_if.sv
// Configuration chain and quiesce handshake bundle between the loader and its neighbours.
interface io_cko_mode_ccff_loader_if #(
  parameter int unsigned MODE_W = 7
);
  logic              ccff_head;
  logic              ccff_shift_en;
  logic              ccff_commit;
  logic              ccff_tail;
  logic              upd_req;
  logic              upd_ack;
  logic [0:MODE_W-1] feedthrough_mem_in;
  logic [0:MODE_W-1] feedthrough_mem_inb;
  logic              cfg_valid;
  logic              cfg_err;

  modport master (
    output ccff_head, ccff_shift_en, ccff_commit, upd_ack,
    input  ccff_tail, upd_req, feedthrough_mem_in, feedthrough_mem_inb, cfg_valid, cfg_err
  );

  modport slave (
    input  ccff_head, ccff_shift_en, ccff_commit, upd_ack,
    output ccff_tail, upd_req, feedthrough_mem_in, feedthrough_mem_inb, cfg_valid, cfg_err
  );
endinterface

// File: rtl/io_cko_mode_ccff_loader_shadow.sv
// CCFF shadow shift register with saturating frame-length counter and even-parity check.
module io_cko_ccff_shadow
  import io_cko_ccff_pkg::*;
#(
  parameter int unsigned MODE_W = MODE_W_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_shift,
  input  logic              i_clear,
  input  logic              i_head,
  output logic [0:MODE_W-1] o_mode,
  output logic              o_tail,
  output logic              o_frame_ok,
  output logic              o_frame_overshift
);
  localparam int unsigned      CNT_W    = cnt_w(MODE_W);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MODE_W + 1);
  localparam logic [CNT_W-1:0] CNT_OVER = CNT_W'(MODE_W + 2);

  logic [0:MODE_W]    r_shadow;
  logic [CNT_W-1:0]   r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shadow <= '0;
      r_cnt    <= '0;
    end else begin
      if (i_clear) begin
        r_cnt <= '0;
      end else if (i_shift && (r_cnt != CNT_OVER)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (i_shift) begin
        r_shadow <= {i_head, r_shadow[0:MODE_W-1]};
      end
    end
  end

  // Parity travels at the far end, so shadow[i] ends up holding mode bit i.
  assign o_mode            = r_shadow[0:MODE_W-1];
  assign o_tail            = r_shadow[MODE_W];
  assign o_frame_ok        = (r_cnt == CNT_FULL) && !(^r_shadow);
  assign o_frame_overshift = (r_cnt == CNT_OVER);

endmodule

// File: rtl/io_cko_mode_ccff_loader.sv
// cko pad-tile mode loader: accepts a CCFF frame and applies it through a stop-clock handshake.
// feedthrough_mem_in[i] carries mode bit i.
module io_cko_mode_ccff_loader
  import io_cko_ccff_pkg::*;
#(
  parameter int unsigned       MODE_W     = MODE_W_DEFAULT,
  parameter logic [MODE_W-1:0] RESET_MODE = '0,
  parameter int unsigned       TIMEOUT    = 255
) (
  input logic                      i_prog_clk,
  input logic                      i_prog_reset_n,
  io_cko_mode_ccff_loader_if.slave io_bus
);
  localparam int unsigned      TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  ccff_state_e       r_state;
  logic [TMO_W-1:0]  r_tmo;
  logic              r_upd_req;
  logic              r_valid;
  logic              r_err;
  logic [0:MODE_W-1] r_mode;
  logic [0:MODE_W-1] r_mode_b;

  logic              w_idle;
  logic              w_shift;
  logic              w_clear;
  logic              w_good;
  logic              w_tail;
  logic              w_frame_ok;
  logic              w_frame_over;
  logic [0:MODE_W-1] w_shadow_mode;

  // A commit wins over a shift in the same cycle and is judged on the pre-shift frame.
  assign w_idle  = (r_state == StIdle);
  assign w_clear = w_idle & io_bus.ccff_commit;
  assign w_shift = w_idle & io_bus.ccff_shift_en & ~io_bus.ccff_commit;
  assign w_good  = w_frame_ok & ~w_frame_over;

  io_cko_ccff_shadow #(
    .MODE_W (MODE_W)
  ) u_shadow (
    .i_clk             (i_prog_clk),
    .i_rst_n           (i_prog_reset_n),
    .i_shift           (w_shift),
    .i_clear           (w_clear),
    .i_head            (io_bus.ccff_head),
    .o_mode            (w_shadow_mode),
    .o_tail            (w_tail),
    .o_frame_ok        (w_frame_ok),
    .o_frame_overshift (w_frame_over)
  );

  always_ff @(posedge i_prog_clk or negedge i_prog_reset_n) begin
    if (!i_prog_reset_n) begin
      r_state   <= StIdle;
      r_tmo     <= '0;
      r_upd_req <= 1'b0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
      for (int unsigned i = 0; i < MODE_W; i++) begin
        r_mode[i]   <= RESET_MODE[i];
        r_mode_b[i] <= ~RESET_MODE[i];
      end
    end else begin
      unique case (r_state)
        StIdle: begin
          if (io_bus.ccff_commit) begin
            if (w_good) begin
              r_state   <= StReq;
              r_upd_req <= 1'b1;
              r_tmo     <= '0;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        StReq: begin
          if (io_bus.upd_ack) begin
            r_state <= StApply;
            r_tmo   <= '0;
          end else if (r_tmo == TMO_LAST) begin
            r_state   <= StIdle;
            r_upd_req <= 1'b0;
            r_err     <= 1'b1;
            r_tmo     <= '0;
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
        end
        StApply: begin
          r_mode   <= w_shadow_mode;
          r_mode_b <= ~w_shadow_mode;
          r_valid  <= 1'b1;
          r_err    <= 1'b0;
          r_state  <= StHold;
          r_tmo    <= '0;
        end
        StHold: begin
          r_state   <= StRel;
          r_upd_req <= 1'b0;
          r_tmo     <= '0;
        end
        StRel: begin
          // A stuck ack leaves the new mode in place but flags the tile.
          if (!io_bus.upd_ack) begin
            r_state <= StIdle;
            r_tmo   <= '0;
          end else if (r_tmo == TMO_LAST) begin
            r_state <= StIdle;
            r_err   <= 1'b1;
            r_tmo   <= '0;
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
        end
        default: begin
          r_state   <= StIdle;
          r_upd_req <= 1'b0;
          r_tmo     <= '0;
        end
      endcase
    end
  end

  assign io_bus.ccff_tail           = w_tail;
  assign io_bus.upd_req             = r_upd_req;
  assign io_bus.feedthrough_mem_in  = r_mode;
  assign io_bus.feedthrough_mem_inb = r_mode_b;
  assign io_bus.cfg_valid           = r_valid;
  assign io_bus.cfg_err             = r_err;

endmodule

// File: tb/tb_io_cko_mode_ccff_loader.sv
// Bench for io_cko_mode_ccff_loader: table vectors, hand sequences and a randomized
// frame stream checked against a queue-based model of the serial chain.
module tb_io_cko_mode_ccff_loader;

  localparam int unsigned MW = 7;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  io_cko_mode_ccff_loader_if #(.MODE_W(MW)) bus ();

  io_cko_mode_ccff_loader #(
    .MODE_W     (MW),
    .RESET_MODE (7'h55),
    .TIMEOUT    (4)
  ) dut (
    .i_prog_clk     (clk),
    .i_prog_reset_n (rst_n),
    .io_bus         (bus)
  );

  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_err = 0;
  bit         hist[$];
  int         nsh;
  logic [6:0] m_mode;

  typedef struct {
    int          n;
    logic [15:0] bits;
    bit          exp_req;
    logic [6:0]  exp_mode;
    bit          exp_err;
  } vec_t;

  vec_t tbl[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk7(input string name, input logic [0:6] act, input logic [0:6] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Bus index i carries mode bit i.
  function automatic logic [0:6] to_bus(input logic [6:0] m);
    logic [0:6] r;
    for (int i = 0; i < 7; i++) r[i] = m[i];
    return r;
  endfunction

  function automatic bit exp_tail();
    return hist[hist.size() - 8];
  endfunction

  function automatic bit model_good();
    bit x = 1'b0;
    if (nsh != 8) return 1'b0;
    for (int i = 0; i < 8; i++) x ^= hist[hist.size() - 1 - i];
    return !x;
  endfunction

  function automatic logic [6:0] model_frame_mode();
    logic [6:0] m;
    for (int i = 0; i < 7; i++) m[i] = hist[hist.size() - 1 - i];
    return m;
  endfunction

  task automatic model_reset();
    hist.delete();
    repeat (8) hist.push_back(1'b0);
    nsh    = 0;
    m_mode = 7'h55;
  endtask

  task automatic shift_bit(input bit b);
    bus.ccff_shift_en = 1'b1;
    bus.ccff_head     = b;
    tick();
    bus.ccff_shift_en = 1'b0;
    hist.push_back(b);
    if (hist.size() > 32) void'(hist.pop_front());
    nsh++;
    chk1("tail", bus.ccff_tail, exp_tail());
  endtask

  task automatic shift_frame(input logic [15:0] bits, input int n);
    for (int j = n - 1; j >= 0; j--) shift_bit(bits[j]);
  endtask

  task automatic do_commit(input bit with_shift, input bit head, input bit good,
                           input int ack_dly, input logic [6:0] new_mode, input bit rel_hang);
    logic [6:0] old_mode;
    old_mode          = m_mode;
    bus.ccff_commit   = 1'b1;
    bus.ccff_shift_en = with_shift;
    bus.ccff_head     = head;
    tick();
    bus.ccff_commit   = 1'b0;
    bus.ccff_shift_en = 1'b0;
    nsh = 0;
    chk1("commit_tail", bus.ccff_tail, exp_tail());
    if (!good) begin
      chk1("bad_req", bus.upd_req, 1'b0);
      chk1("bad_err", bus.cfg_err, 1'b1);
      chk7("bad_mode", bus.feedthrough_mem_in, to_bus(old_mode));
      tick();
      chk1("bad_req_late", bus.upd_req, 1'b0);
      return;
    end
    chk1("req_rise", bus.upd_req, 1'b1);
    repeat (ack_dly) begin
      tick();
      chk1("req_wait", bus.upd_req, 1'b1);
      chk7("mode_wait", bus.feedthrough_mem_in, to_bus(old_mode));
    end
    bus.upd_ack = 1'b1;
    tick();
    chk1("req_at_ack", bus.upd_req, 1'b1);
    chk7("mode_at_ack", bus.feedthrough_mem_in, to_bus(old_mode));
    tick();
    chk7("mode_apply", bus.feedthrough_mem_in, to_bus(new_mode));
    chk7("modeb_apply", bus.feedthrough_mem_inb, to_bus(~new_mode));
    chk1("req_hold", bus.upd_req, 1'b1);
    chk1("valid_apply", bus.cfg_valid, 1'b1);
    chk1("err_apply", bus.cfg_err, 1'b0);
    tick();
    chk1("req_fall", bus.upd_req, 1'b0);
    m_mode = new_mode;
    if (rel_hang) begin
      repeat (3) begin
        tick();
        chk1("rel_wait_err", bus.cfg_err, 1'b0);
      end
      tick();
      chk1("rel_tmo_err", bus.cfg_err, 1'b1);
      chk7("rel_tmo_mode", bus.feedthrough_mem_in, to_bus(new_mode));
    end
    bus.upd_ack = 1'b0;
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ccff_head     = 1'b0;
    bus.ccff_shift_en = 1'b0;
    bus.ccff_commit   = 1'b0;
    bus.upd_ack       = 1'b0;
    model_reset();

    tbl[0] = '{8, 16'h005A, 1'b1, 7'h5A, 1'b0};
    tbl[1] = '{8, 16'h00DA, 1'b0, 7'h5A, 1'b1};
    tbl[2] = '{8, 16'h00FF, 1'b1, 7'h7F, 1'b0};
    tbl[3] = '{7, 16'h005A, 1'b0, 7'h7F, 1'b1};
    tbl[4] = '{8, 16'h0000, 1'b1, 7'h00, 1'b0};
    tbl[5] = '{9, 16'h005A, 1'b0, 7'h00, 1'b1};
    tbl[6] = '{8, 16'h0081, 1'b1, 7'h01, 1'b0};

    #1 rst_n = 1'b0;
    #2;
    chk1("rst_tail", bus.ccff_tail, 1'b0);
    chk1("rst_req", bus.upd_req, 1'b0);
    chk7("rst_mode", bus.feedthrough_mem_in, to_bus(7'h55));
    chk7("rst_modeb", bus.feedthrough_mem_inb, to_bus(7'h2A));
    chk1("rst_valid", bus.cfg_valid, 1'b0);
    chk1("rst_err", bus.cfg_err, 1'b0);
    #7 rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      shift_frame(tbl[i].bits, tbl[i].n);
      do_commit(1'b0, 1'b0, tbl[i].exp_req, 3 - (i % 4), tbl[i].exp_mode, 1'b0);
      chk7("tbl_mode", bus.feedthrough_mem_in, to_bus(tbl[i].exp_mode));
      chk1("tbl_err", bus.cfg_err, tbl[i].exp_err);
    end

    // Commit with a same-cycle shift: full frame accepted unshifted, short frame rejected.
    shift_frame(16'h000F, 8);
    do_commit(1'b1, 1'b1, 1'b1, 0, 7'h0F, 1'b0);
    shift_frame(16'h0033, 7);
    do_commit(1'b1, 1'b0, 1'b0, 0, 7'h0F, 1'b0);

    // Ack never arrives; shift attempts during the request must not move the chain.
    shift_frame(16'h0033, 8);
    bus.ccff_commit = 1'b1;
    tick();
    bus.ccff_commit = 1'b0;
    nsh = 0;
    chk1("to_req", bus.upd_req, 1'b1);
    bus.ccff_shift_en = 1'b1;
    bus.ccff_head     = 1'b1;
    repeat (3) begin
      tick();
      chk1("to_req_hold", bus.upd_req, 1'b1);
    end
    tick();
    bus.ccff_shift_en = 1'b0;
    chk1("to_req_fall", bus.upd_req, 1'b0);
    chk1("to_err", bus.cfg_err, 1'b1);
    chk7("to_mode", bus.feedthrough_mem_in, to_bus(m_mode));
    chk1("to_tail", bus.ccff_tail, exp_tail());

    // Ack stuck high after apply.
    shift_frame(16'h0081, 8);
    do_commit(1'b0, 1'b0, 1'b1, 1, 7'h01, 1'b1);

    // Asynchronous reset in the middle of a request.
    shift_frame(16'h005A, 8);
    bus.ccff_commit = 1'b1;
    tick();
    bus.ccff_commit = 1'b0;
    chk1("mid_req", bus.upd_req, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    chk1("mid_rst_req", bus.upd_req, 1'b0);
    chk7("mid_rst_mode", bus.feedthrough_mem_in, to_bus(7'h55));
    chk7("mid_rst_modeb", bus.feedthrough_mem_inb, to_bus(7'h2A));
    chk1("mid_rst_valid", bus.cfg_valid, 1'b0);
    chk1("mid_rst_err", bus.cfg_err, 1'b0);
    chk1("mid_rst_tail", bus.ccff_tail, 1'b0);
    #1 rst_n = 1'b1;
    model_reset();

    for (int it = 0; it < 40; it++) begin
      int          n;
      int          sel;
      logic [6:0]  m;
      logic [15:0] bits;
      bit          par;
      bit          good;
      sel = $urandom_range(0, 9);
      n   = (sel < 6) ? 8 : (sel == 6) ? 6 : (sel == 7) ? 7 : (sel == 8) ? 9 : 10;
      m   = 7'($urandom_range(0, 127));
      par = ^m;
      if ($urandom_range(0, 3) == 0) par = ~par;
      bits      = 16'($urandom);
      bits[7:0] = {par, m};
      for (int j = n - 1; j >= 0; j--) begin
        if ($urandom_range(0, 3) == 0) begin
          tick();
          chk1("gap_tail", bus.ccff_tail, exp_tail());
        end
        shift_bit(bits[j]);
      end
      good = model_good();
      do_commit(($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)), good,
                $urandom_range(0, 3), model_frame_mode(), 1'b0);
      chk7("rnd_mode", bus.feedthrough_mem_in, to_bus(m_mode));
      chk1("rnd_err", bus.cfg_err, !good);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
